// File: rtl/setare_pkg.sv
// Shared constants for the time-setting path: state codes, field ranges and widths.
// The display and timekeeper blocks import the same definitions.
package setare_pkg;
    localparam int ORE_W   = 5;
    localparam int MIN_W   = 6;
    localparam int MAX_ORE = 23;
    localparam int MAX_MIN = 59;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SET_ORE = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'b00,
        FIELD_ORE  = 2'b01,
        FIELD_MIN  = 2'b10
    } field_t;

    function automatic logic [ORE_W-1:0] clamp_ore(input logic [ORE_W-1:0] v);
        return (v > ORE_W'(MAX_ORE)) ? ORE_W'(MAX_ORE) : v;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
        return (v > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : v;
    endfunction
endpackage

// File: rtl/setare_if.sv
// Button/time inputs and display/load outputs of the time-setting controller.
interface setare_if;
    import setare_pkg::*;

    logic             btn_mode;
    logic             btn_up;
    logic             btn_down;
    logic             tick;
    logic [ORE_W-1:0] ore;
    logic [MIN_W-1:0] minute;
    logic             semnal_setare;
    logic [ORE_W-1:0] ore_setare;
    logic [MIN_W-1:0] minute_setare;
    logic [1:0]       field_sel;
    logic             load;

    modport master (
        output btn_mode, btn_up, btn_down, tick, ore, minute,
        input  semnal_setare, ore_setare, minute_setare, field_sel, load
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, tick, ore, minute,
        output semnal_setare, ore_setare, minute_setare, field_sel, load
    );
endinterface

// File: rtl/setare_controller_btn_edge.sv
// Rising-edge detector for a debounced button level.
// History resets to 1 so a button held through reset never yields a press.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic btn_q;

    always_ff @(posedge clock) begin
        if (reset) btn_q <= 1'b1;
        else       btn_q <= btn;
    end

    assign press = btn & ~btn_q;
endmodule

// File: rtl/setare_controller.sv
// Button-driven time-setting sequencer: capture running time, edit hours then
// minutes, and strobe load so the timekeeper adopts the edited time.
//
// state      | meaning
// IDLE       | display follows running time, waiting for mode press
// SET_ORE    | editing hours, up/down wrap 0..23
// SET_MIN    | editing minutes, up/down wrap 0..59
// COMMIT     | one-cycle load strobe, then back to IDLE
module setare_controller
    import setare_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 10
) (
    input logic   clock,
    input logic   reset,
    setare_if.slave bus
);
    localparam int              CNT_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS);

    logic             p_mode, p_up, p_down;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [ORE_W-1:0] ore_q;
    logic [MIN_W-1:0] min_q;
    logic             any_press;
    logic             step_up, step_down;

    btn_edge u_edge_mode (.clock(clock), .reset(reset), .btn(bus.btn_mode), .press(p_mode));
    btn_edge u_edge_up   (.clock(clock), .reset(reset), .btn(bus.btn_up),   .press(p_up));
    btn_edge u_edge_down (.clock(clock), .reset(reset), .btn(bus.btn_down), .press(p_down));

    assign any_press = p_mode | p_up | p_down;
    assign step_up   = p_up & ~p_down;
    assign step_down = p_down & ~p_up;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ore_q <= '0;
            min_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (p_mode) begin
                        ore_q <= clamp_ore(bus.ore);
                        min_q <= clamp_min(bus.minute);
                        state <= ST_SET_ORE;
                    end
                end
                ST_SET_ORE, ST_SET_MIN: begin
                    if (p_mode) begin
                        cnt   <= '0;
                        state <= (state == ST_SET_ORE) ? ST_SET_MIN : ST_COMMIT;
                    end else begin
                        if (state == ST_SET_ORE) begin
                            if (step_up)
                                ore_q <= (ore_q == ORE_W'(MAX_ORE)) ? '0 : ore_q + ORE_W'(1);
                            else if (step_down)
                                ore_q <= (ore_q == '0) ? ORE_W'(MAX_ORE) : ore_q - ORE_W'(1);
                        end else begin
                            if (step_up)
                                min_q <= (min_q == MIN_W'(MAX_MIN)) ? '0 : min_q + MIN_W'(1);
                            else if (step_down)
                                min_q <= (min_q == '0) ? MIN_W'(MAX_MIN) : min_q - MIN_W'(1);
                        end
                        // A press in the same cycle as a tick keeps the edit alive.
                        if (any_press) begin
                            cnt <= '0;
                        end else if (bus.tick) begin
                            if (cnt_inc == CNT_MAX) begin
                                cnt   <= '0;
                                state <= ST_IDLE;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.semnal_setare = (state != ST_IDLE);
        bus.load          = (state == ST_COMMIT);
        bus.field_sel     = FIELD_NONE;
        if (state == ST_SET_ORE) bus.field_sel = FIELD_ORE;
        if (state == ST_SET_MIN) bus.field_sel = FIELD_MIN;
    end

    assign bus.ore_setare    = ore_q;
    assign bus.minute_setare = min_q;
endmodule
